// File: rtl/l2_cache_nway.sv
// N-way set-associative write-back L2 cache with tree pseudo-LRU.
// Ports: clk/rst; upstream mem_* request/response; downstream pmem_* line
// bus; perf_clr clears the hit_count/miss_count event counters.
module l2_cache_nway #(
  parameter int WAYS   = 4,
  parameter int SETS   = 64,
  parameter int ADDR_W = 16,
  parameter int UP_W   = 128,
  parameter int DN_W   = 256,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] mem_address,
  input  logic [UP_W-1:0]   mem_wdata,
  output logic              mem_resp,
  output logic [UP_W-1:0]   mem_rdata,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [DN_W-1:0]   pmem_wdata,
  input  logic [DN_W-1:0]   pmem_rdata,
  input  logic              pmem_resp,
  input  logic              perf_clr,
  output logic [CNT_W-1:0]  hit_count,
  output logic [CNT_W-1:0]  miss_count
);

  localparam int OFF   = $clog2(DN_W / 8);
  localparam int UOFF  = $clog2(UP_W / 8);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = ADDR_W - OFF - IDX_W;
  localparam int WAY_W = $clog2(WAYS);
  localparam int NSUB  = DN_W / UP_W;
  localparam int SUB_W = (NSUB > 1) ? $clog2(NSUB) : 1;

  typedef enum logic [1:0] {
    CHECK,
    WRITEBACK,
    ALLOCATE
  } state_t;

  state_t state_q, state_d;

  logic [SETS-1:0]  valid_q [WAYS];
  logic [SETS-1:0]  dirty_q [WAYS];
  logic [TAG_W-1:0] tag_q   [WAYS][SETS];
  logic [DN_W-1:0]  data_q  [WAYS][SETS];
  logic [WAYS-2:0]  plru_q  [SETS];

  logic [WAY_W-1:0] victim_q, victim, plru_way, hit_way;
  logic [WAYS-1:0]  hit_vec;
  logic [WAYS-2:0]  plru_cur, plru_nxt;
  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;
  logic [SUB_W-1:0] sub;
  logic [DN_W-1:0]  hit_line;
  logic             req, hit, miss_ev, wr_hit, fill, missed_q;

  assign idx = mem_address[OFF +: IDX_W];
  assign tag = mem_address[ADDR_W-1 -: TAG_W];
  assign sub = (NSUB > 1) ? SUB_W'(mem_address >> UOFF) : '0;
  assign req = mem_read | mem_write;

  always_comb begin
    hit_vec = '0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      hit_vec[w] = valid_q[w][idx] && (tag_q[w][idx] == tag);
      if (hit_vec[w]) hit_way = WAY_W'(w);
    end
  end

  assign hit       = $onehot(hit_vec);
  assign hit_line  = data_q[hit_way][idx];
  assign mem_rdata = hit_line[sub*UP_W +: UP_W];
  assign plru_cur  = plru_q[idx];

  // Tree walk: node n has children 2n+1 / 2n+2; a 0 bit steers left.
  always_comb begin
    int n;
    n = 0;
    for (int l = 0; l < WAY_W; l++)
      n = 2 * n + 1 + int'(plru_cur[n]);
    plru_way = WAY_W'(n - (WAYS - 1));
  end

  // Each node on the path points at the sibling of the touched subtree.
  always_comb begin
    int n, p;
    plru_nxt = plru_cur;
    n = int'(hit_way) + WAYS - 1;
    for (int l = 0; l < WAY_W; l++) begin
      p = (n - 1) / 2;
      plru_nxt[p] = n[0];
      n = p;
    end
  end

  always_comb begin
    logic found;
    found  = 1'b0;
    victim = plru_way;
    for (int w = 0; w < WAYS; w++) begin
      if (!valid_q[w][idx] && !found) begin
        victim = WAY_W'(w);
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    mem_resp     = 1'b0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    pmem_wdata   = '0;
    unique case (state_q)
      CHECK: begin
        mem_resp = req && hit;
        if (req && !hit)
          state_d = (valid_q[victim][idx] && dirty_q[victim][idx])
                    ? WRITEBACK : ALLOCATE;
      end
      WRITEBACK: begin
        pmem_write   = 1'b1;
        pmem_address = {tag_q[victim_q][idx], idx, {OFF{1'b0}}};
        pmem_wdata   = data_q[victim_q][idx];
        if (pmem_resp) state_d = ALLOCATE;
      end
      ALLOCATE: begin
        pmem_read    = 1'b1;
        pmem_address = {tag, idx, {OFF{1'b0}}};
        if (pmem_resp) state_d = CHECK;
      end
      default: state_d = CHECK;
    endcase
    if (rst) begin
      mem_resp   = 1'b0;
      pmem_read  = 1'b0;
      pmem_write = 1'b0;
    end
  end

  assign miss_ev = !rst && state_q == CHECK && req && !hit;
  assign wr_hit  = mem_resp && mem_write;
  assign fill    = !rst && state_q == ALLOCATE && pmem_resp;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= CHECK;
      victim_q <= '0;
      for (int w = 0; w < WAYS; w++) begin
        valid_q[w] <= '0;
        dirty_q[w] <= '0;
      end
      for (int s = 0; s < SETS; s++) plru_q[s] <= '0;
    end else begin
      state_q <= state_d;
      if (miss_ev) victim_q <= victim;
      if (fill) begin
        valid_q[victim_q][idx] <= 1'b1;
        dirty_q[victim_q][idx] <= 1'b0;
      end
      if (wr_hit) dirty_q[hit_way][idx] <= 1'b1;
      if (mem_resp) plru_q[idx] <= plru_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (fill) begin
      tag_q[victim_q][idx]  <= tag;
      data_q[victim_q][idx] <= pmem_rdata;
    end else if (wr_hit) begin
      data_q[hit_way][idx][sub*UP_W +: UP_W] <= mem_wdata;
    end
  end

  // A response that follows a fill belongs to a request already counted
  // as a miss, so it must not also count as a hit.
  always_ff @(posedge clk) begin
    if (rst) begin
      missed_q   <= 1'b0;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (mem_resp)     missed_q <= 1'b0;
      else if (miss_ev) missed_q <= 1'b1;
      if (perf_clr)                  hit_count <= '0;
      else if (mem_resp && !missed_q) hit_count <= hit_count + 1'b1;
      if (perf_clr)     miss_count <= '0;
      else if (miss_ev) miss_count <= miss_count + 1'b1;
    end
  end

endmodule
